led_frame_sequencer: RTL and testbench
======================================

// Module: led_frame_sequencer
// PURPOSE
//  Frame-level scheduler for the WS2812B strip driver. On a debounced start request it walks
//  NUM_LEDS 24-bit GRB words out of a frame RAM, hands each to the serial bit encoder over a
//  valid/ready handshake, then holds the line low for the latch interval.
//  Sits between the button/debounce front end and the NZR bit generator.
//  Drives the LED index shown on the 7-segment display.
// PARAMETERS
//  NUM_LEDS      8     pixels per frame (1..255)
//  LATCH_CYCLES  6000  low time after last pixel, in clk cycles (60 us at 100 MHz; min 2)
//  ADDR_W        8     frame RAM address width; must satisfy 2**ADDR_W >= NUM_LEDS
// PORTS
//  clk         in   1       system clock, all logic rising-edge
//  reset       in   1       asynchronous, active-high; clears all state
//  go          in   1       frame start request, level; sampled only in IDLE
//  stop        in   1       abort request, level
//  clr         in   1       blank frame: send zeros instead of RAM data; sampled with go
//  ram_addr    out  ADDR_W  frame RAM read address
//  ram_rd      out  1       RAM read strobe; data valid on ram_data the following cycle
//  ram_data    in   24      GRB word, G[23:16] R[15:8] B[7:0], MSB sent first
//  pix_data    out  24      pixel word to bit encoder
//  pix_valid   out  1       pix_data valid
//  pix_ready   in   1       encoder can accept; transfer when pix_valid & pix_ready
//  latch       out  1       high throughout the latch interval (encoder holds line low)
//  ready2go    out  1       high in IDLE only
//  frame_done  out  1       one-cycle pulse on LATCH->IDLE
//  led_index   out  8       index of pixel currently in flight (display)
// BEHAVIOUR
//  Reset values: ram_addr=0, ram_rd=0, pix_data=0, pix_valid=0, latch=0, ready2go=1,
//   frame_done=0, led_index=0. FSM returns to IDLE from any state on reset.
//  FSM (all outputs registered):
//   IDLE : ready2go=1. go=1 -> latch blank<=clr, idx<=0, ram_addr<=0, ram_rd<=1 -> FETCH.
//          stop in IDLE is ignored.
//   FETCH: ram_rd=1 for exactly one cycle -> WAIT.
//   WAIT : pix_data<=(blank ? 24'h0 : ram_data), pix_valid<=1 -> SEND.
//   SEND : pix_valid held and pix_data stable until pix_ready.
//          On transfer, pix_valid<=0, then:
//           - if stop sampled high this cycle, or idx==NUM_LEDS-1: -> LATCH;
//           - else idx<=idx+1, ram_addr<=idx+1, ram_rd<=1 -> FETCH.
//   LATCH: latch=1, timer counts LATCH_CYCLES cycles.
//          On expiry -> IDLE with frame_done=1 for one cycle; go still high then does NOT
//          restart in that cycle (restart is at the earliest the next cycle).
//  - Pixel-to-pixel gap overhead: 3 cycles (FETCH, WAIT, SEND-entry) plus encoder stall.
//  - stop never truncates a pixel already presented: a valid word is always accepted before
//    LATCH, so the strip never receives a partial 24-bit word.
//  - go/clr while busy: ignored. stop and last-pixel simultaneous: single LATCH, no double count.
//  - idx is 8 bit; it never wraps because the terminal compare is NUM_LEDS-1.
//    led_index = idx, held in LATCH, cleared to 0 on IDLE entry.
//  - Asynchronous reset mid-SEND drops pix_valid immediately. The encoder is reset by the same
//    signal, so no handshake is left dangling.
// STRUCTURE
//  Shared include ws2812_defs.vh:
//   - state encodings (IDLE, FETCH, WAIT, SEND, LATCH);
//   - GRB_W=24;
//   - default LATCH_CYCLES.
//  Sub-module latch_timer: load/count-down counter, width $clog2(LATCH_CYCLES+1), one-cycle
//   expire pulse, asynchronous reset. Shared later with the encoder's reset-gap logic.
//  Remainder (FSM, index, pixel register) in this module.
// TESTING
//  1 Reset: assert reset mid-SEND -> all outputs at reset values same cycle; ready2go=1.
//  2 Full frame: NUM_LEDS=4, RAM={0x00FF00,0xFF0000,0x0000FF,0x123456}, pix_ready=1
//    -> 4 transfers in address order, exact words; latch high for 6000 cycles;
//    single frame_done pulse.
//  3 Backpressure: pix_ready low for 10 cycles on pixel 2 -> pix_data/pix_valid stable the
//    whole stall; RAM not re-read.
//  4 Clear: go with clr=1, RAM nonzero -> 4 transfers of 24'h000000, no other change.
//  5 Stop: stop high during pixel 1 SEND -> pixel 1 accepted, LATCH entered, pixels 2-3
//    never sent; led_index=1.
//  6 Back-to-back: go held high -> new frame starts 1 cycle after frame_done;
//    go/clr toggled during SEND ignored.

Source files
------------

// File: rtl/led_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module : led_frame_sequencer_pkg
//  Shared widths, defaults and FSM state encoding for the WS2812B sequencer.
//  Rev    : 1.0
// ============================================================================
package led_frame_sequencer_pkg;

    localparam int c_grb_w            = 24;
    localparam int c_def_latch_cycles = 6000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_LATCH = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/led_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module : led_frame_sequencer_if
//  Frame RAM read port plus pixel valid/ready handshake to the bit encoder.
//  Rev    : 1.0
// ============================================================================
interface led_frame_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0]                          ram_addr;
    logic                                       ram_rd;
    logic [led_frame_sequencer_pkg::c_grb_w-1:0] ram_data;
    logic [led_frame_sequencer_pkg::c_grb_w-1:0] pix_data;
    logic                                       pix_valid;
    logic                                       pix_ready;

    modport master (
        output ram_addr, ram_rd, pix_data, pix_valid,
        input  ram_data, pix_ready
    );

    modport slave (
        input  ram_addr, ram_rd, pix_data, pix_valid,
        output ram_data, pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/led_frame_sequencer_latch_timer.sv
`default_nettype none
// ============================================================================
//  Module : led_frame_sequencer_latch_timer
//  Load/count-down timer; o_expire is high in the last counted cycle.
//  Rev    : 1.0
// ============================================================================
module led_frame_sequencer_latch_timer #(
    parameter int CYCLES = 6000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    output logic      o_expire
);
    localparam int               CNT_W  = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] c_load = CNT_W'(CYCLES);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    // Loaded with N, so the owner sees N cycles before this pulse takes effect.
    assign o_expire = (r_cnt == c_one);

endmodule
`default_nettype wire

// File: rtl/led_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : led_frame_sequencer
//  Walks a frame of GRB words from RAM to the bit encoder, then latches.
//  Rev    : 1.0
// ============================================================================
module led_frame_sequencer
    import led_frame_sequencer_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int LATCH_CYCLES = c_def_latch_cycles,
    parameter int ADDR_W       = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             go,
    input  wire logic             stop,
    input  wire logic             clr,
    led_frame_sequencer_if.master bus,
    output logic                  latch,
    output logic                  ready2go,
    output logic                  frame_done,
    output logic [7:0]            led_index
);
    localparam logic [7:0] c_last = 8'(NUM_LEDS - 1);

    seq_state_t         r_state,      w_state_nxt;
    logic [7:0]         r_idx,        w_idx_nxt;
    logic               r_blank,      w_blank_nxt;
    logic [ADDR_W-1:0]  r_addr,       w_addr_nxt;
    logic               r_rd,         w_rd_nxt;
    logic [c_grb_w-1:0] r_pix_data,   w_pix_data_nxt;
    logic               r_pix_valid,  w_pix_valid_nxt;
    logic               r_latch,      w_latch_nxt;
    logic               r_ready2go,   w_ready2go_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic               w_timer_load;
    logic               w_expire;

    led_frame_sequencer_latch_timer #(
        .CYCLES (LATCH_CYCLES)
    ) u_latch_timer (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_timer_load),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_blank      <= 1'b0;
            r_addr       <= '0;
            r_rd         <= 1'b0;
            r_pix_data   <= '0;
            r_pix_valid  <= 1'b0;
            r_latch      <= 1'b0;
            r_ready2go   <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_blank      <= w_blank_nxt;
            r_addr       <= w_addr_nxt;
            r_rd         <= w_rd_nxt;
            r_pix_data   <= w_pix_data_nxt;
            r_pix_valid  <= w_pix_valid_nxt;
            r_latch      <= w_latch_nxt;
            r_ready2go   <= w_ready2go_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_blank_nxt      = r_blank;
        w_addr_nxt       = r_addr;
        w_rd_nxt         = 1'b0;
        w_pix_data_nxt   = r_pix_data;
        w_pix_valid_nxt  = r_pix_valid;
        w_latch_nxt      = r_latch;
        w_ready2go_nxt   = r_ready2go;
        w_frame_done_nxt = 1'b0;
        w_timer_load     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_blank_nxt    = clr;
                    w_idx_nxt      = '0;
                    w_addr_nxt     = '0;
                    w_rd_nxt       = 1'b1;
                    w_ready2go_nxt = 1'b0;
                    w_state_nxt    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_pix_data_nxt  = r_blank ? '0 : bus.ram_data;
                w_pix_valid_nxt = 1'b1;
                w_state_nxt     = ST_SEND;
            end
            ST_SEND: begin
                // stop only acts on a completed transfer so no word is cut short
                if (bus.pix_ready) begin
                    w_pix_valid_nxt = 1'b0;
                    if (stop || (r_idx == c_last)) begin
                        w_latch_nxt  = 1'b1;
                        w_timer_load = 1'b1;
                        w_state_nxt  = ST_LATCH;
                    end else begin
                        w_idx_nxt   = r_idx + 8'd1;
                        w_addr_nxt  = ADDR_W'(r_idx + 8'd1);
                        w_rd_nxt    = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_LATCH: begin
                if (w_expire) begin
                    w_latch_nxt      = 1'b0;
                    w_frame_done_nxt = 1'b1;
                    w_ready2go_nxt   = 1'b1;
                    w_idx_nxt        = '0;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.ram_addr  = r_addr;
    assign bus.ram_rd    = r_rd;
    assign bus.pix_data  = r_pix_data;
    assign bus.pix_valid = r_pix_valid;
    assign latch         = r_latch;
    assign ready2go      = r_ready2go;
    assign frame_done    = r_frame_done;
    assign led_index     = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : tb_led_frame_sequencer
//  Scoreboard bench for led_frame_sequencer with a 4-pixel frame.
//  Rev    : 1.0
// ============================================================================
module tb_led_frame_sequencer;
    localparam int NUM_LEDS     = 4;
    localparam int LATCH_CYCLES = 6000;
    localparam int ADDR_W       = 8;
    localparam int BUDGET       = 8000;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       go    = 1'b0;
    logic       stop  = 1'b0;
    logic       clr   = 1'b0;
    logic       latch;
    logic       ready2go;
    logic       frame_done;
    logic [7:0] led_index;

    led_frame_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    led_frame_sequencer #(
        .NUM_LEDS     (NUM_LEDS),
        .LATCH_CYCLES (LATCH_CYCLES),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .stop       (stop),
        .clr        (clr),
        .bus        (bus),
        .latch      (latch),
        .ready2go   (ready2go),
        .frame_done (frame_done),
        .led_index  (led_index)
    );

    always #5 clk = ~clk;

    logic [23:0] ram [0:3];
    initial begin
        ram[0] = 24'h00FF00;
        ram[1] = 24'hFF0000;
        ram[2] = 24'h0000FF;
        ram[3] = 24'h123456;
    end

    always @(posedge clk) begin
        if (bus.ram_rd) bus.ram_data <= ram[bus.ram_addr[1:0]];
    end

    int          checks = 0;
    int          failures = 0;
    int          xfers = 0;
    int          reads = 0;
    int          dones = 0;
    int          stalls = 0;
    int          latch_run = 0;
    int          last_latch_len = 0;
    int          latch_idx = 0;
    logic [23:0] exp_q [$];
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_latch = 1'b0;
    logic        prev_done  = 1'b0;
    logic [23:0] prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and tracks frame-level events.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_latch = 1'b0;
            prev_done  = 1'b0;
            latch_run  = 0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 32'(bus.pix_valid), 32'd1);
                check("stall_data", 32'(bus.pix_data), 32'(prev_data));
            end
            if (bus.pix_valid && bus.pix_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pixel: got %06h expected no transfer", bus.pix_data);
                end else begin
                    check("pix_data", 32'(bus.pix_data), 32'(exp_q.pop_front()));
                end
            end
            if (bus.pix_valid && !bus.pix_ready) stalls++;
            if (bus.ram_rd) reads++;
            if (latch) begin
                if (!prev_latch) latch_idx = int'(led_index);
                latch_run++;
            end else if (prev_latch) begin
                last_latch_len = latch_run;
                latch_run      = 0;
            end
            if (frame_done) begin
                dones++;
                check("done_pulse_width", 32'(prev_done), 32'd0);
            end
            prev_valid = bus.pix_valid;
            prev_ready = bus.pix_ready;
            prev_data  = bus.pix_data;
            prev_latch = latch;
            prev_done  = frame_done;
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < BUDGET);
        if (!frame_done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no frame_done expected one within %0d cycles", name, BUDGET);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pix_valid && n < BUDGET);
        if (!bus.pix_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no pix_valid expected one", name);
        end
    endtask

    task automatic wait_fetch(input string name, input logic [7:0] addr);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.ram_rd && bus.ram_addr == addr) && n < BUDGET);
        if (!(bus.ram_rd && bus.ram_addr == addr)) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no read of %0d expected one", name, addr);
        end
    endtask

    task automatic start_frame(input logic c);
        @(posedge clk); #1;
        go  = 1'b1;
        clr = c;
        @(posedge clk); #1;
        go  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic frame_checks(input string name, input int xb, input int rb, input int db,
                                input int ex, input int er, input int ed, input int eidx);
        repeat (2) @(negedge clk);
        #1;
        check({name, "_xfers"}, 32'(xfers - xb), 32'(ex));
        check({name, "_reads"}, 32'(reads - rb), 32'(er));
        check({name, "_dones"}, 32'(dones - db), 32'(ed));
        check({name, "_latch_len"}, 32'(last_latch_len), 32'(LATCH_CYCLES));
        check({name, "_latch_idx"}, 32'(latch_idx), 32'(eidx));
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idx_idle"}, 32'(led_index), 32'd0);
        check({name, "_ready2go"}, 32'(ready2go), 32'd1);
    endtask

    int xb, rb, db, sb;

    initial begin
        bus.pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_rd", 32'(bus.ram_rd), 32'd0);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_latch", 32'(latch), 32'd0);
        check("rst_ready2go", 32'(ready2go), 32'd1);
        check("rst_led_index", 32'(led_index), 32'd0);
        reset = 1'b0;

        // Full frame, encoder always ready
        xb = xfers; rb = reads; db = dones;
        for (int i = 0; i < NUM_LEDS; i++) exp_q.push_back(ram[i]);
        start_frame(1'b0);
        wait_done("full");
        frame_checks("full", xb, rb, db, 4, 4, 1, 3);

        // Ten-cycle stall on pixel 2
        xb = xfers; rb = reads; db = dones; sb = stalls;
        for (int i = 0; i < NUM_LEDS; i++) exp_q.push_back(ram[i]);
        start_frame(1'b0);
        wait_fetch("bp_fetch2", 8'd2);
        @(posedge clk); #1;
        bus.pix_ready = 1'b0;
        wait_valid("bp_valid");
        repeat (9) @(negedge clk);
        @(posedge clk); #1;
        bus.pix_ready = 1'b1;
        wait_done("bp");
        frame_checks("bp", xb, rb, db, 4, 4, 1, 3);
        check("bp_stall_cycles", 32'(stalls - sb), 32'd10);

        // Blank frame
        xb = xfers; rb = reads; db = dones;
        for (int i = 0; i < NUM_LEDS; i++) exp_q.push_back(24'h000000);
        start_frame(1'b1);
        wait_done("clr");
        frame_checks("clr", xb, rb, db, 4, 4, 1, 3);

        // Stop raised for pixel 1
        xb = xfers; rb = reads; db = dones;
        exp_q.push_back(ram[0]);
        exp_q.push_back(ram[1]);
        start_frame(1'b0);
        wait_fetch("stop_fetch1", 8'd1);
        @(posedge clk); #1;
        stop = 1'b1;
        wait_valid("stop_valid");
        @(posedge clk); #1;
        stop = 1'b0;
        wait_done("stop");
        frame_checks("stop", xb, rb, db, 2, 2, 1, 1);

        // Back-to-back with go held; clr and go pulses while busy must be ignored
        xb = xfers; rb = reads; db = dones;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < NUM_LEDS; i++) exp_q.push_back(ram[i]);
        @(posedge clk); #1;
        go = 1'b1;
        wait_valid("b2b_valid1");
        @(posedge clk); #1;
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        wait_done("b2b1");
        check("b2b_done_cycle_rd", 32'(bus.ram_rd), 32'd0);
        check("b2b_done_cycle_ready2go", 32'(ready2go), 32'd1);
        @(negedge clk);
        check("b2b_restart_rd", 32'(bus.ram_rd), 32'd1);
        check("b2b_restart_addr", 32'(bus.ram_addr), 32'd0);
        check("b2b_restart_ready2go", 32'(ready2go), 32'd0);
        @(posedge clk); #1;
        go = 1'b0;
        wait_valid("b2b_valid2");
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        wait_done("b2b2");
        frame_checks("b2b", xb, rb, db, 8, 8, 2, 3);
        repeat (10) @(negedge clk);
        #1;
        check("b2b_no_third_frame", 32'(reads - rb), 32'd8);

        // Asynchronous reset while a pixel is being held
        start_frame(1'b0);
        bus.pix_ready = 1'b0;
        wait_valid("rst_valid");
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("arst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("arst_pix_data", 32'(bus.pix_data), 32'd0);
        check("arst_ram_rd", 32'(bus.ram_rd), 32'd0);
        check("arst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("arst_latch", 32'(latch), 32'd0);
        check("arst_ready2go", 32'(ready2go), 32'd1);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        check("arst_led_index", 32'(led_index), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_ready2go", 32'(ready2go), 32'd1);
        check("post_rst_pix_valid", 32'(bus.pix_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
